onehot_debounce8: RTL and testbench

Input-conditioning stage that sits directly upstream of the 8-to-3 encoder. It synchronizes and debounces eight raw key/request lines, qualifies a single clean press, and presents it as a registered one-hot vector with a valid/ready handshake. The encoder consumes that vector and produces the 3-bit index. Multi-key presses are rejected and flagged, so the encoder only ever sees legal one-hot or all-zero input.

---
 rtl/onehot_debounce8.sv | 132 +++++++++++++
 tb/tb_onehot_debounce8.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/onehot_debounce8.sv
// Request-line conditioner for the 8-to-3 encoder. It synchronizes and debounces
// eight raw lines and hands one clean one-hot press downstream over valid/ready.
module onehot_debounce8 #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] raw_in,
    output logic [7:0] A,
    output logic       valid,
    input  logic       ready,
    output logic       multi_err
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    logic [7:0]       r_sync_p0;
    logic [7:0]       r_sync_p1;
    logic [7:0]       r_stable;
    logic [CNT_W-1:0] r_cnt [8];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_a;
    logic [7:0]       w_a_nxt;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_merr;
    logic             w_merr_nxt;

    logic             w_any;
    logic             w_onehot;

    // Stage p0/p1: two-flop synchronizer, no filtering ahead of it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
        end else begin
            r_sync_p0 <= raw_in;
            r_sync_p1 <= r_sync_p0;
        end
    end

    // Debounce: a bit flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= '0;
            for (int i = 0; i < 8; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (r_sync_p1[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= r_sync_p1[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign w_any    = (r_stable != 8'd0);
    assign w_onehot = w_any && ((r_stable & (r_stable - 8'd1)) == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_valid <= 1'b0;
            r_merr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_valid <= w_valid_nxt;
            r_merr  <= w_merr_nxt;
        end
    end

    // Only the first nonzero stable vector matters; HOLD ignores later changes
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_valid_nxt = r_valid;
        w_merr_nxt  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_onehot) begin
                    w_a_nxt     = r_stable;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = HOLD;
                end else if (w_any) begin
                    w_merr_nxt  = 1'b1;
                    w_state_nxt = WAIT_REL;
                end
            end
            HOLD: begin
                if (r_valid && ready) begin
                    w_a_nxt     = '0;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!w_any) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_a_nxt     = '0;
                w_valid_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign A         = r_a;
    assign valid     = r_valid;
    assign multi_err = r_merr;

endmodule

// File: tb/tb_onehot_debounce8.sv
// Bench for onehot_debounce8: table of single presses plus hand-built corner
// sequences, with expected captures and error pulses queued and checked on arrival.
module tb_onehot_debounce8;

    localparam int D   = 4;
    localparam int LAT = D + 3;  // drive cycle -> cycle valid is first seen high

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw_in;
    logic [7:0] A;
    logic       valid;
    logic       ready;
    logic       multi_err;

    onehot_debounce8 #(.DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in),
        .A         (A),
        .valid     (valid),
        .ready     (ready),
        .multi_err (multi_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        bit         merr;
        int         len;
    } exp_t;

    typedef struct {
        logic [7:0] raw;
        int         kind;   // 0 nothing, 1 capture, 2 multi-key error
        logic [7:0] exp_a;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    vec_t vecs[8];
    int   cyc = 0;
    int   run = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_valid = 1'b0;
    logic prev_merr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push(input int c, input logic [7:0] a, input bit merr, input int len);
        exp_t e;
        e.cyc = c; e.a = a; e.merr = merr; e.len = len;
        sb.push_back(e);
    endtask

    // One clock: advance past the edge, then check outputs on the falling edge
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("a_legal", (valid ? ($countones(A) == 1) : (A == 8'd0)), 1);
        chk("merr_pulse", multi_err && prev_merr, 0);
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            chk("missed_event", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if ((valid && !prev_valid) || multi_err) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", {22'd0, valid, multi_err, A}, 0);
            end else begin
                e = sb.pop_front();
                chk("evt_cyc", cyc, e.cyc);
                chk("evt_merr", multi_err, e.merr);
                chk("evt_valid", valid, !e.merr);
                chk("evt_a", A, e.merr ? 8'd0 : e.a);
                if (!e.merr) begin
                    cur = e;
                    run = 0;
                end
            end
        end
        if (valid) begin
            run++;
            chk("a_hold", A, cur.a);
        end
        if (prev_valid && !valid) chk("valid_len", run, cur.len);
        prev_valid = valid;
        prev_merr  = multi_err;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int c;
        vecs[0] = '{8'h20, 1, 8'h20};
        vecs[1] = '{8'h01, 1, 8'h01};
        vecs[2] = '{8'h80, 1, 8'h80};
        vecs[3] = '{8'h06, 2, 8'h00};
        vecs[4] = '{8'h01, 1, 8'h01};
        vecs[5] = '{8'hC0, 2, 8'h00};
        vecs[6] = '{8'h00, 0, 8'h00};
        vecs[7] = '{8'h08, 1, 8'h08};

        // Reset with all lines high must not leak a capture
        rst = 1'b1; raw_in = 8'hFF; ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_a", A, 8'h00);
            chk("rst_valid", valid, 0);
            chk("rst_merr", multi_err, 0);
        end
        rst = 1'b0; raw_in = 8'h00;
        ticks(12);
        chk("idle_valid", valid, 0);

        // Table: press, hold (no second capture allowed), release
        ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            raw_in = vecs[v].raw;
            if (vecs[v].kind != 0) push(cyc + LAT, vecs[v].exp_a, vecs[v].kind == 2, 1);
            ticks(14);
            raw_in = 8'h00;
            ticks(14);
        end

        // Bounce on bit 3, then a clean hold
        raw_in = 8'h08; tick();
        raw_in = 8'h00; tick();
        raw_in = 8'h08; tick();
        raw_in = 8'h00; tick();
        raw_in = 8'h08;
        push(cyc + LAT, 8'h08, 0, 1);
        ticks(12);
        raw_in = 8'h00;
        ticks(14);

        // 3-cycle glitch on bit 0 is filtered out
        raw_in = 8'h01;
        ticks(3);
        raw_in = 8'h00;
        ticks(14);
        chk("glitch_valid", valid, 0);

        // Backpressure: held across release, transfer on first ready edge
        ready = 1'b0; raw_in = 8'h80;
        c = cyc;
        push(c + LAT, 8'h80, 0, 44);
        ticks(20);
        raw_in = 8'h00;
        ticks(30);
        chk("bp_valid", valid, 1);
        chk("bp_a", A, 8'h80);
        ready = 1'b1;
        tick();
        chk("bp_after_valid", valid, 0);
        chk("bp_after_a", A, 8'h00);
        ticks(14);
        raw_in = 8'h04;
        push(cyc + LAT, 8'h04, 0, 1);
        ticks(12);
        raw_in = 8'h00;
        ticks(14);

        // Reset during HOLD drops the press; held key is captured again
        ready = 1'b0; raw_in = 8'h10;
        c = cyc;
        push(c + LAT, 8'h10, 0, 3);
        ticks(9);
        chk("hold_valid", valid, 1);
        rst = 1'b1; ready = 1'b1;
        tick();
        chk("midrst_a", A, 8'h00);
        chk("midrst_valid", valid, 0);
        rst = 1'b0;
        push(c + 17, 8'h10, 0, 1);
        ticks(12);
        raw_in = 8'h00;
        ticks(14);

        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
